// File: rtl/execute_mdu_stage.sv
// EX stage of the PSRV32 pipeline: operand forwarding, ALU, branch resolution, single-cycle MUL
// and an iterative restoring divider, ending in the EX/MEM pipeline register.
module execute_mdu_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REGA_W  = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    read_data1_i,
    input  logic [XLEN-1:0]    read_data2_i,
    input  logic [XLEN-1:0]    offset_i,
    input  logic [REGA_W-1:0]  rd_i,
    input  logic               regwrite_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic               alusrc_i,
    input  logic               isbranch_i,
    input  logic [2:0]         br_type_i,
    input  logic [1:0]         fwd_a_i,
    input  logic [1:0]         fwd_b_i,
    input  logic [XLEN-1:0]    mem_fwd_data_i,
    input  logic [XLEN-1:0]    wb_fwd_data_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    alu_result_o,
    output logic [XLEN-1:0]    read_data2_o,
    output logic [REGA_W-1:0]  write_reg_o,
    output logic               regwrite_o,
    output logic               branch_taken_o,
    output logic [XLEN-1:0]    pc_ifbranch_o
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CntLast = SHW'(XLEN - 2);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [ALUOP_W-1:0] OpSub  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OpSll  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OpSlt  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OpSltu = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OpXor  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OpSrl  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OpSra  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OpOr   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OpAnd  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OpMul  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OpDiv  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OpDivu = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] OpRem  = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] OpRemu = ALUOP_W'(14);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] op1, rs2_fwd, op2, alu_res, pc_target;
    logic [SHW-1:0]  shamt;
    logic            br_cond, taken, accept;

    logic            is_div_op, div_signed, div_rem, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            neg_quo_q, neg_rem_q, is_rem_q, special_q;
    logic [XLEN:0]   rem_sh, diff;
    logic            step_bit;
    logic [XLEN-1:0] step_rem, step_quo, quo_fix, rem_fix, div_res;

    logic [REGA_W-1:0] pend_rd_q;
    logic              pend_regwrite_q, pend_taken_q;
    logic [XLEN-1:0]   pend_store_q, pend_target_q;

    logic              valid_q, regwrite_q, taken_q;
    logic [XLEN-1:0]   result_q, store_q, target_q;
    logic [REGA_W-1:0] wreg_q;

    logic load_alu, load_div, out_clear, div_start, div_iter;

    always_comb begin
        unique case (fwd_a_i)
            2'd0:    op1 = read_data1_i;
            2'd1:    op1 = mem_fwd_data_i;
            2'd2:    op1 = wb_fwd_data_i;
            default: op1 = '0;
        endcase
        unique case (fwd_b_i)
            2'd0:    rs2_fwd = read_data2_i;
            2'd1:    rs2_fwd = mem_fwd_data_i;
            2'd2:    rs2_fwd = wb_fwd_data_i;
            default: rs2_fwd = '0;
        endcase
    end

    assign op2       = alusrc_i ? offset_i : rs2_fwd;
    assign shamt     = op2[SHW-1:0];
    assign pc_target = pc_i + offset_i;

    always_comb begin
        alu_res = op1 + op2;
        case (aluop_i)
            OpSub:   alu_res = op1 - op2;
            OpSll:   alu_res = op1 << shamt;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            OpXor:   alu_res = op1 ^ op2;
            OpSrl:   alu_res = op1 >> shamt;
            OpSra:   alu_res = $signed(op1) >>> shamt;
            OpOr:    alu_res = op1 | op2;
            OpAnd:   alu_res = op1 & op2;
            OpMul:   alu_res = op1 * op2;
            default: ;
        endcase
    end

    always_comb begin
        case (br_type_i)
            3'd0:    br_cond = (op1 == rs2_fwd);
            3'd1:    br_cond = (op1 != rs2_fwd);
            3'd4:    br_cond = ($signed(op1) < $signed(rs2_fwd));
            3'd5:    br_cond = ($signed(op1) >= $signed(rs2_fwd));
            3'd6:    br_cond = (op1 < rs2_fwd);
            3'd7:    br_cond = (op1 >= rs2_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    assign taken = isbranch_i & br_cond;

    // Divide setup: work on magnitudes, remember how to fix the signs afterwards.
    assign is_div_op  = (aluop_i == OpDiv) | (aluop_i == OpDivu) |
                        (aluop_i == OpRem) | (aluop_i == OpRemu);
    assign div_signed = (aluop_i == OpDiv) | (aluop_i == OpRem);
    assign div_rem    = (aluop_i == OpRem) | (aluop_i == OpRemu);
    assign a_neg      = div_signed & op1[XLEN-1];
    assign b_neg      = div_signed & op2[XLEN-1];
    assign a_mag      = a_neg ? -op1 : op1;
    assign b_mag      = b_neg ? -op2 : op2;
    assign div_zero   = (op2 == '0);
    assign div_ovf    = div_signed & (op1 == MinNeg) & (op2 == '1);

    always_comb begin
        if (div_zero) special_res = div_rem ? op1 : '1;
        else          special_res = div_rem ? '0 : MinNeg;
    end

    // One restoring step; the DIV state runs XLEN-1 of them and DONE applies the last one
    // combinationally, so the registers stay stable while DONE waits out a stall.
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign step_bit = ~diff[XLEN];
    assign step_rem = step_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], step_bit};
    assign quo_fix  = neg_quo_q ? -step_quo : step_quo;
    assign rem_fix  = neg_rem_q ? -step_rem : step_rem;
    assign div_res  = special_q ? quo_q : (is_rem_q ? rem_fix : quo_fix);

    assign ready_o = (state_q == StIdle) & ~stall_i & ~reset_i;
    assign accept  = valid_i & ready_o & ~flush_i;

    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_div  = 1'b0;
        out_clear = 1'b0;
        div_start = 1'b0;
        div_iter  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && is_div_op) begin
                    div_start = 1'b1;
                    out_clear = 1'b1;
                    state_d   = (div_zero | div_ovf) ? StDone : StDiv;
                end else if (accept) begin
                    load_alu = 1'b1;
                end else if (!stall_i) begin
                    out_clear = 1'b1;
                end
            end
            StDiv: begin
                div_iter  = 1'b1;
                out_clear = ~stall_i;
                if (cnt_q == CntLast) state_d = StDone;
            end
            StDone: begin
                if (!stall_i) begin
                    load_div = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d   = StIdle;
            load_alu  = 1'b0;
            load_div  = 1'b0;
            div_start = 1'b0;
            div_iter  = 1'b0;
            out_clear = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            dvs_q           <= '0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            is_rem_q        <= 1'b0;
            special_q       <= 1'b0;
            pend_rd_q       <= '0;
            pend_regwrite_q <= 1'b0;
            pend_taken_q    <= 1'b0;
            pend_store_q    <= '0;
            pend_target_q   <= '0;
            valid_q         <= 1'b0;
            regwrite_q      <= 1'b0;
            taken_q         <= 1'b0;
            result_q        <= '0;
            store_q         <= '0;
            target_q        <= '0;
            wreg_q          <= '0;
        end else begin
            state_q <= state_d;
            if (div_start) begin
                cnt_q           <= '0;
                rem_q           <= '0;
                quo_q           <= (div_zero | div_ovf) ? special_res : a_mag;
                dvs_q           <= b_mag;
                neg_quo_q       <= a_neg ^ b_neg;
                neg_rem_q       <= a_neg;
                is_rem_q        <= div_rem;
                special_q       <= div_zero | div_ovf;
                pend_rd_q       <= rd_i;
                pend_regwrite_q <= regwrite_i;
                pend_taken_q    <= taken;
                pend_store_q    <= rs2_fwd;
                pend_target_q   <= pc_target;
            end else if (div_iter) begin
                cnt_q <= cnt_q + SHW'(1);
                rem_q <= step_rem;
                quo_q <= step_quo;
            end
            if (load_alu) begin
                valid_q    <= 1'b1;
                result_q   <= alu_res;
                store_q    <= rs2_fwd;
                wreg_q     <= rd_i;
                regwrite_q <= regwrite_i;
                taken_q    <= taken;
                target_q   <= pc_target;
            end else if (load_div) begin
                valid_q    <= 1'b1;
                result_q   <= div_res;
                store_q    <= pend_store_q;
                wreg_q     <= pend_rd_q;
                regwrite_q <= pend_regwrite_q;
                taken_q    <= pend_taken_q;
                target_q   <= pend_target_q;
            end else if (out_clear) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                taken_q    <= 1'b0;
            end
        end
    end

    assign valid_o        = valid_q;
    assign alu_result_o   = result_q;
    assign read_data2_o   = store_q;
    assign write_reg_o    = wreg_q;
    assign regwrite_o     = regwrite_q;
    assign branch_taken_o = taken_q;
    assign pc_ifbranch_o  = target_q;

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Bench for execute_mdu_stage: directed corner cases plus randomized ALU, branch and divide
// traffic checked against a plain-arithmetic reference model.
module tb_execute_mdu_stage;
    logic        clk = 1'b0;
    logic        reset_i, valid_i, ready_o;
    logic [31:0] pc_i, read_data1_i, read_data2_i, offset_i;
    logic [4:0]  rd_i;
    logic        regwrite_i;
    logic [3:0]  aluop_i;
    logic        alusrc_i, isbranch_i;
    logic [2:0]  br_type_i;
    logic [1:0]  fwd_a_i, fwd_b_i;
    logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
    logic        stall_i, flush_i, valid_o;
    logic [31:0] alu_result_o, read_data2_o, pc_ifbranch_o;
    logic [4:0]  write_reg_o;
    logic        regwrite_o, branch_taken_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_mdu_stage #(.XLEN(32), .REGA_W(5), .ALUOP_W(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .read_data1_i(read_data1_i), .read_data2_i(read_data2_i), .offset_i(offset_i),
        .rd_i(rd_i), .regwrite_i(regwrite_i), .aluop_i(aluop_i), .alusrc_i(alusrc_i),
        .isbranch_i(isbranch_i), .br_type_i(br_type_i), .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i),
        .mem_fwd_data_i(mem_fwd_data_i), .wb_fwd_data_i(wb_fwd_data_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_o(valid_o), .alu_result_o(alu_result_o),
        .read_data2_o(read_data2_o), .write_reg_o(write_reg_o), .regwrite_o(regwrite_o),
        .branch_taken_o(branch_taken_o), .pc_ifbranch_o(pc_ifbranch_o)
    );

    function automatic logic is_ovf(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            4'd1:  r = a - b;
            4'd2:  r = a << b[4:0];
            4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  r = (a < b) ? 32'd1 : 32'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> b[4:0];
            4'd7:  r = sa >>> b[4:0];
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = a * b;
            4'd11: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (is_ovf(a, b)) r = 32'h8000_0000;
                else r = sa / sb;
            end
            4'd12: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else r = a / b;
            end
            4'd13: begin
                if (b == 0) r = a;
                else if (is_ovf(a, b)) r = 32'd0;
                else r = sa % sb;
            end
            4'd14: begin
                if (b == 0) r = a;
                else r = a % b;
            end
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic ref_branch(input logic [2:0] bt, input logic [31:0] a,
                                        input logic [31:0] b);
        case (bt)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd0) return r;
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return 32'd0;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 16);
            1:       return 32'hFFFF_FFFF - $urandom_range(0, 16);
            2:       return 32'h8000_0000 ^ $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        valid_i = 0; pc_i = 0; read_data1_i = 0; read_data2_i = 0; offset_i = 0; rd_i = 0;
        regwrite_i = 0; aluop_i = 0; alusrc_i = 0; isbranch_i = 0; br_type_i = 0;
        fwd_a_i = 0; fwd_b_i = 0; mem_fwd_data_i = 0; wb_fwd_data_i = 0; stall_i = 0;
        flush_i = 0;
    endtask

    // Present one register-operand instruction and let it be accepted on the next edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        clear_inputs;
        valid_i = 1; aluop_i = op; read_data1_i = a; read_data2_i = b; rd_i = rd;
        regwrite_i = 1; pc_i = 32'h200; offset_i = 32'h10;
        tick;
        valid_i = 0;
    endtask

    task automatic test_reset;
        clear_inputs;
        reset_i = 1;
        tick;
        tick;
        total++;
        if ({valid_o, alu_result_o, read_data2_o, write_reg_o, regwrite_o, branch_taken_o,
             pc_ifbranch_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b res=%h rd2=%h wr=%0d rw=%b bt=%b pc=%h, want 0",
                     valid_o, alu_result_o, read_data2_o, write_reg_o, regwrite_o,
                     branch_taken_o, pc_ifbranch_o);
        end
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0", ready_o);
        end
        reset_i = 0;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", ready_o);
        end
    endtask

    task automatic test_add_fwd;
        clear_inputs;
        valid_i = 1; aluop_i = 4'd0; fwd_a_i = 2'd1; mem_fwd_data_i = 32'hFFFF_FFFF;
        read_data1_i = 32'h1234; read_data2_i = 32'd1; rd_i = 5'd5; regwrite_i = 1;
        #1;
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL add_fwd_before: valid=%b want 0", valid_o);
        end
        tick;
        total++;
        if (valid_o !== 1'b1 || alu_result_o !== 32'd0 || write_reg_o !== 5'd5) begin
            bad++;
            $display("FAIL add_fwd: valid=%b res=%h wr=%0d, want valid=1 res=0 wr=5",
                     valid_o, alu_result_o, write_reg_o);
        end
        clear_inputs;
        tick;
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL add_bubble: valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_alu_random;
        logic [31:0] r1, r2, m, w, off, pc, e_op1, e_rs2, e_op2, e_res, e_tgt;
        logic [3:0]  op;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op == 4'd11) op = 4'd15;
            r1 = rnd_val(); r2 = rnd_val(); m = rnd_val(); w = rnd_val();
            off = rnd_val(); pc = $urandom; rd = 5'($urandom);
            clear_inputs;
            valid_i = 1; aluop_i = op; read_data1_i = r1; read_data2_i = r2; offset_i = off;
            mem_fwd_data_i = m; wb_fwd_data_i = w; pc_i = pc; rd_i = rd; regwrite_i = 1;
            fwd_a_i = 2'($urandom); fwd_b_i = 2'($urandom); alusrc_i = 1'($urandom);
            e_op1 = fwd_val(fwd_a_i, r1, m, w);
            e_rs2 = fwd_val(fwd_b_i, r2, m, w);
            e_op2 = alusrc_i ? off : e_rs2;
            e_res = ref_alu(op, e_op1, e_op2);
            e_tgt = pc + off;
            tick;
            total++;
            if (valid_o !== 1'b1 || alu_result_o !== e_res) begin
                bad++;
                $display("FAIL alu_random[%0d] op=%0d a=%h b=%h: valid=%b res=%h want res=%h",
                         i, op, e_op1, e_op2, valid_o, alu_result_o, e_res);
            end
            total++;
            if ({read_data2_o, write_reg_o, regwrite_o, branch_taken_o, pc_ifbranch_o} !==
                {e_rs2, rd, 1'b1, 1'b0, e_tgt}) begin
                bad++;
                $display("FAIL alu_side[%0d]: rd2=%h wr=%0d rw=%b bt=%b pc=%h want %h %0d 1 0 %h",
                         i, read_data2_o, write_reg_o, regwrite_o, branch_taken_o,
                         pc_ifbranch_o, e_rs2, rd, e_tgt);
            end
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_branch;
        logic [2:0]  bts [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] a, b;
        logic        exp_t;
        // Directed BLT/BLTU on -1 vs 1 and a backward target.
        for (int k = 0; k < 2; k++) begin
            clear_inputs;
            valid_i = 1; isbranch_i = 1; br_type_i = (k == 0) ? 3'd4 : 3'd6;
            read_data1_i = 32'hFFFF_FFFF; read_data2_i = 32'd1; alusrc_i = 1;
            pc_i = 32'h100; offset_i = 32'hFFFF_FFFC; aluop_i = 4'd1;
            tick;
            total++;
            if (valid_o !== 1'b1 || branch_taken_o !== (k == 0) ||
                pc_ifbranch_o !== 32'h0000_00FC) begin
                bad++;
                $display("FAIL branch_directed[%0d]: valid=%b taken=%b pc=%h want 1 %0d 000000fc",
                         k, valid_o, branch_taken_o, pc_ifbranch_o, (k == 0));
            end
        end
        for (int i = 0; i < 24; i++) begin
            a = rnd_val();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_val();
            clear_inputs;
            valid_i = 1; isbranch_i = 1; br_type_i = bts[$urandom_range(0, 5)];
            fwd_a_i = 2'd2; wb_fwd_data_i = a; fwd_b_i = 2'd1; mem_fwd_data_i = b;
            read_data1_i = ~a; read_data2_i = ~b; alusrc_i = 1; offset_i = $urandom;
            exp_t = ref_branch(br_type_i, a, b);
            tick;
            total++;
            if (valid_o !== 1'b1 || branch_taken_o !== exp_t) begin
                bad++;
                $display("FAIL branch_random[%0d] bt=%0d a=%h b=%h: taken=%b want %b",
                         i, br_type_i, a, b, branch_taken_o, exp_t);
            end
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_div_directed;
        logic [3:0]  ops  [6] = '{4'd11, 4'd13, 4'd12, 4'd11, 4'd13, 4'd14};
        logic [31:0] as   [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000,
                                  32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs   [6] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'd0, 32'h1234_5678};
        int          lats [6] = '{33, 33, 2, 2, 2, 2};
        int          lat;
        logic        ready_low;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], as[i], bs[i], 5'(i + 10));
            lat = 1;
            ready_low = 1;
            while (valid_o !== 1'b1 && lat < 100) begin
                if (ready_o !== 1'b0) ready_low = 0;
                tick;
                lat++;
            end
            total++;
            if (lat != lats[i] || alu_result_o !== exps[i]) begin
                bad++;
                $display("FAIL div_directed[%0d]: res=%h lat=%0d want res=%h lat=%0d",
                         i, alu_result_o, lat, exps[i], lats[i]);
            end
            total++;
            if (!ready_low || write_reg_o !== 5'(i + 10) || pc_ifbranch_o !== 32'h210) begin
                bad++;
                $display("FAIL div_side[%0d]: ready_low=%b wr=%0d pc=%h want 1 %0d 00000210",
                         i, ready_low, write_reg_o, pc_ifbranch_o, i + 10);
            end
        end
        tick;
    endtask

    task automatic test_div_random;
        logic [3:0]  op;
        logic [31:0] a, b, e;
        int          lat, e_lat;
        for (int i = 0; i < 14; i++) begin
            op = 4'($urandom_range(11, 14));
            a = rnd_val();
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : rnd_val();
            if (i % 7 == 0) b = 32'd0;
            if (i % 7 == 1) begin
                op = (i % 2 == 0) ? 4'd11 : 4'd13; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (i % 7 == 2 && $urandom_range(0, 1) == 1) a = -a;
            e = ref_alu(op, a, b);
            e_lat = (b == 0 || ((op == 4'd11 || op == 4'd13) && is_ovf(a, b))) ? 2 : 33;
            send(op, a, b, 5'd3);
            lat = 1;
            while (valid_o !== 1'b1 && lat < 100) begin
                tick;
                lat++;
            end
            total++;
            if (lat != e_lat || alu_result_o !== e) begin
                bad++;
                $display("FAIL div_random[%0d] op=%0d a=%h b=%h: res=%h lat=%0d want %h lat=%0d",
                         i, op, a, b, alu_result_o, lat, e, e_lat);
            end
        end
        tick;
    endtask

    task automatic test_stall;
        logic held_ok;
        int   lat;
        // EX/MEM holds while stalled and nothing is accepted.
        send(4'd0, 32'd3, 32'd4, 5'd7);
        valid_i = 1; aluop_i = 4'd1; read_data1_i = 32'd10; read_data2_i = 32'd1; rd_i = 5'd9;
        stall_i = 1;
        #1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready: got %b want 0", ready_o);
        end
        tick;
        tick;
        total++;
        if (valid_o !== 1'b1 || alu_result_o !== 32'd7 || write_reg_o !== 5'd7) begin
            bad++;
            $display("FAIL stall_hold: valid=%b res=%h wr=%0d want 1 7 7",
                     valid_o, alu_result_o, write_reg_o);
        end
        stall_i = 0;
        tick;
        total++;
        if (valid_o !== 1'b1 || alu_result_o !== 32'd9 || write_reg_o !== 5'd9) begin
            bad++;
            $display("FAIL stall_release: valid=%b res=%h wr=%0d want 1 9 9",
                     valid_o, alu_result_o, write_reg_o);
        end
        // Stall for three cycles once the divide has reached DONE.
        send(4'd12, 32'd100, 32'd7, 5'd4);
        for (int i = 0; i < 31; i++) tick;
        held_ok = (valid_o === 1'b0);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (valid_o !== 1'b0) held_ok = 0;
        end
        total++;
        if (!held_ok) begin
            bad++;
            $display("FAIL stall_done_hold: valid=%b want 0 while stalled", valid_o);
        end
        stall_i = 0;
        tick;
        total++;
        if (valid_o !== 1'b1 || alu_result_o !== 32'd14) begin
            bad++;
            $display("FAIL stall_done_emit: valid=%b res=%h want 1 0000000e", valid_o, alu_result_o);
        end
        // A stall during the iteration does not lengthen it.
        send(4'd12, 32'd1000, 32'd10, 5'd4);
        for (int i = 0; i < 5; i++) tick;
        stall_i = 1;
        for (int i = 0; i < 3; i++) tick;
        stall_i = 0;
        lat = 9;
        while (valid_o !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        total++;
        if (lat != 33 || alu_result_o !== 32'd100) begin
            bad++;
            $display("FAIL stall_mid_div: res=%h lat=%0d want 00000064 lat=33", alu_result_o, lat);
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_flush;
        logic quiet;
        send(4'd11, 32'd500, 32'd3, 5'd6);
        for (int i = 0; i < 5; i++) tick;
        valid_i = 1; aluop_i = 4'd0; read_data1_i = 32'd1; read_data2_i = 32'd1; flush_i = 1;
        tick;
        clear_inputs;
        #1;
        total++;
        if ({valid_o, regwrite_o, branch_taken_o} !== 3'b000 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_div: valid=%b rw=%b bt=%b ready=%b want 0 0 0 1",
                     valid_o, regwrite_o, branch_taken_o, ready_o);
        end
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (valid_o !== 1'b0) quiet = 0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL flush_abandon: valid=%b want 0 after abandoned divide", valid_o);
        end
        // Flush wins over stall.
        clear_inputs;
        valid_i = 1; isbranch_i = 1; br_type_i = 3'd0; regwrite_i = 1;
        read_data1_i = 32'd8; read_data2_i = 32'd8;
        tick;
        stall_i = 1; flush_i = 1; valid_i = 0;
        tick;
        total++;
        if ({valid_o, regwrite_o, branch_taken_o} !== 3'b000) begin
            bad++;
            $display("FAIL flush_over_stall: valid=%b rw=%b bt=%b want 0 0 0",
                     valid_o, regwrite_o, branch_taken_o);
        end
        clear_inputs;
        tick;
    endtask

    task automatic test_reset_mid_div;
        send(4'd0, 32'd1, 32'd2, 5'd3);
        send(4'd11, 32'hFFFF_FF00, 32'd7, 5'd8);
        for (int i = 0; i < 10; i++) tick;
        reset_i = 1;
        tick;
        total++;
        if ({valid_o, alu_result_o, read_data2_o, write_reg_o, regwrite_o, branch_taken_o,
             pc_ifbranch_o} !== '0 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_div: valid=%b res=%h wr=%0d pc=%h ready=%b want all 0",
                     valid_o, alu_result_o, write_reg_o, pc_ifbranch_o, ready_o);
        end
        reset_i = 0;
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_div_ready: got %b want 1", ready_o);
        end
        send(4'd0, 32'd5, 32'd6, 5'd1);
        total++;
        if (valid_o !== 1'b1 || alu_result_o !== 32'd11) begin
            bad++;
            $display("FAIL reset_mid_div_recover: valid=%b res=%h want 1 0000000b",
                     valid_o, alu_result_o);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [$];
        logic [31:0] a, b, e;
        logic [3:0]  op;
        logic        accepted;
        int          guard;
        for (int i = 0; i < 10; i++) begin
            op = (i == 4) ? 4'd13 : 4'($urandom_range(0, 10));
            a = rnd_val();
            b = (i == 4) ? 32'($urandom_range(1, 50)) : rnd_val();
            clear_inputs;
            valid_i = 1; aluop_i = op; read_data1_i = a; read_data2_i = b; rd_i = 5'(i);
            e = ref_alu(op, a, b);
            accepted = 0;
            guard = 0;
            while (!accepted && guard < 100) begin
                accepted = ready_o;
                tick;
                guard++;
                if (accepted) exp_q.push_back(e);
                if (valid_o === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL b2b_extra: unexpected valid result %h", alu_result_o);
                    end else if (alu_result_o !== exp_q[0]) begin
                        bad++;
                        $display("FAIL b2b_result: got %h want %h", alu_result_o, exp_q[0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        clear_inputs;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            tick;
            if (valid_o === 1'b1) begin
                total++;
                if (alu_result_o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL b2b_drain: got %h want %h", alu_result_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_missing: %0d results never appeared, want 0", exp_q.size());
        end
    endtask

    initial begin
        clear_inputs;
        reset_i = 1;
        test_reset;
        test_add_fwd;
        test_alu_random;
        test_branch;
        test_div_directed;
        test_div_random;
        test_stall;
        test_flush;
        test_reset_mid_div;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
